// File: rtl/ca_seq_checker_8bit.sv
// Receive-side checker for the 8-bit hybrid rule-90/150 CA test sequence.
// Seeds an internal CA model from received data (HUNT/VERIFY), then runs the
// model free and scores every valid word against it (LOCKED). Mismatches while
// locked produce an error pulse and bump a saturating counter; a run of
// LOSS_THRESH consecutive mismatches drops lock back to HUNT.
module ca_seq_checker_8bit #(
    parameter int LOCK_COUNT  = 4,   // consecutive matches needed to lock (1..15)
    parameter int LOSS_THRESH = 3,   // consecutive misses that drop lock (1..15)
    parameter int ERR_W       = 16   // error counter width
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    input  logic [7:0]       in_data_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             error_o,
    output logic             lock_lost_o,
    output logic [ERR_W-1:0] err_count_o
);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [7:0]         exp_q, exp_d;
    logic [3:0]         match_q, match_d;
    logic [3:0]         miss_q, miss_d;
    logic               locked_q, locked_d;
    logic               error_q, error_d;
    logic               lost_q, lost_d;
    logic [ERR_W-1:0]   cnt_q, cnt_d;

    logic               count_err;
    logic [4:0]         match_inc;
    logic [4:0]         miss_inc;

    // Next CA state: rule 150 cells at bits 5, 3, 1, rule 90 elsewhere,
    // with zero (null) boundaries beyond bit 7 and bit 0.
    function automatic logic [7:0] ca_next(input logic [7:0] s);
        logic [7:0] n;
        n[7] = s[6];
        n[6] = s[7] ^ s[5];
        n[5] = s[6] ^ s[5] ^ s[4];
        n[4] = s[5] ^ s[3];
        n[3] = s[4] ^ s[3] ^ s[2];
        n[2] = s[3] ^ s[1];
        n[1] = s[2] ^ s[1] ^ s[0];
        n[0] = s[1];
        return n;
    endfunction

    assign match_inc = {1'b0, match_q} + 5'd1;
    assign miss_inc  = {1'b0, miss_q} + 5'd1;

    // Next-state logic: FSM, CA model, run counters and registered outputs.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        match_d   = match_q;
        miss_d    = miss_q;
        error_d   = 1'b0;
        lost_d    = 1'b0;
        count_err = 1'b0;

        if (in_valid_i) begin
            unique case (state_q)
                HUNT: begin
                    // Zero is a fixed point of the CA, so it never seeds.
                    if (in_data_i != 8'h00) begin
                        exp_d   = ca_next(in_data_i);
                        match_d = 4'd0;
                        state_d = VERIFY;
                    end
                end
                VERIFY: begin
                    if (in_data_i == exp_q) begin
                        exp_d   = ca_next(in_data_i);
                        match_d = match_inc[3:0];
                        if (match_inc == 5'(LOCK_COUNT)) begin
                            miss_d  = 4'd0;
                            state_d = LOCKED;
                        end
                    end else if (in_data_i != 8'h00) begin
                        exp_d   = ca_next(in_data_i);
                        match_d = 4'd0;
                    end else begin
                        state_d = HUNT;
                    end
                end
                LOCKED: begin
                    // Free-running model: never reseeded from data here.
                    exp_d = ca_next(exp_q);
                    if (in_data_i == exp_q) begin
                        miss_d = 4'd0;
                    end else begin
                        error_d   = 1'b1;
                        count_err = 1'b1;
                        miss_d    = miss_inc[3:0];
                        if (miss_inc == 5'(LOSS_THRESH)) begin
                            lost_d  = 1'b1;
                            state_d = HUNT;
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end

        // Clear takes priority over a same-edge increment.
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (count_err && (cnt_q != {ERR_W{1'b1}})) begin
            cnt_d = cnt_q + {{(ERR_W-1){1'b0}}, 1'b1};
        end

        locked_d = (state_d == LOCKED);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= HUNT;
            exp_q    <= 8'h00;
            match_q  <= 4'd0;
            miss_q   <= 4'd0;
            locked_q <= 1'b0;
            error_q  <= 1'b0;
            lost_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            exp_q    <= exp_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            error_q  <= error_d;
            lost_q   <= lost_d;
            cnt_q    <= cnt_d;
        end
    end

    assign locked_o    = locked_q;
    assign error_o     = error_q;
    assign lock_lost_o = lost_q;
    assign err_count_o = cnt_q;

endmodule

// File: tb/tb_ca_seq_checker_8bit.sv
// Self-checking bench for ca_seq_checker_8bit: constant vector table, directed
// corner-case sequences, and a randomized stream scored by a reference model.
module tb_ca_seq_checker_8bit;

    localparam int LOCK_COUNT  = 4;
    localparam int LOSS_THRESH = 3;
    localparam int ERR_W       = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni;
    logic             in_valid_i;
    logic [7:0]       in_data_i;
    logic             clear_i;
    logic             locked_o;
    logic             error_o;
    logic             lock_lost_o;
    logic [ERR_W-1:0] err_count_o;

    int checks = 0;
    int errors = 0;

    ca_seq_checker_8bit #(
        .LOCK_COUNT (LOCK_COUNT),
        .LOSS_THRESH(LOSS_THRESH),
        .ERR_W      (ERR_W)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .in_valid_i (in_valid_i),
        .in_data_i  (in_data_i),
        .clear_i    (clear_i),
        .locked_o   (locked_o),
        .error_o    (error_o),
        .lock_lost_o(lock_lost_o),
        .err_count_o(err_count_o)
    );

    always #5 clk_i = ~clk_i;

    // CA step from the rule description: each cell XORs its neighbours, and
    // rule-150 cells (bits 5,3,1) also XOR themselves; shifts give null edges.
    function automatic logic [7:0] f(input logic [7:0] s);
        return (s << 1) ^ (s >> 1) ^ (s & 8'h2A);
    endfunction

    // Reference model, kept as plain spec-level bookkeeping.
    int          m_mode;          // 0 hunt, 1 verify, 2 locked
    logic [7:0]  m_exp;
    int          m_match, m_miss, m_cnt;
    logic        m_locked, m_error, m_lost;

    task automatic model_reset();
        m_mode = 0; m_exp = 8'h00; m_match = 0; m_miss = 0; m_cnt = 0;
        m_locked = 0; m_error = 0; m_lost = 0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d, input logic c);
        m_error = 0;
        m_lost  = 0;
        if (v) begin
            if (m_mode == 0) begin
                if (d != 0) begin m_exp = f(d); m_match = 0; m_mode = 1; end
            end else if (m_mode == 1) begin
                if (d == m_exp) begin
                    m_exp = f(d); m_match++;
                    if (m_match == LOCK_COUNT) begin m_mode = 2; m_miss = 0; end
                end else if (d != 0) begin
                    m_exp = f(d); m_match = 0;
                end else begin
                    m_mode = 0;
                end
            end else begin
                if (d == m_exp) begin
                    m_miss = 0;
                end else begin
                    m_error = 1;
                    if (m_cnt < (1 << ERR_W) - 1) m_cnt++;
                    m_miss++;
                    if (m_miss == LOSS_THRESH) begin m_mode = 0; m_lost = 1; end
                end
                m_exp = f(m_exp);
            end
        end
        if (c) m_cnt = 0;
        m_locked = (m_mode == 2);
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        check("model.locked", int'(locked_o), int'(m_locked));
        check("model.error", int'(error_o), int'(m_error));
        check("model.lock_lost", int'(lock_lost_o), int'(m_lost));
        check("model.err_count", int'(err_count_o), m_cnt);
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input logic v, input logic [7:0] d, input logic c);
        @(negedge clk_i);
        in_valid_i = v;
        in_data_i  = d;
        clear_i    = c;
        @(posedge clk_i);
        model_step(v, d, c);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       c;
        logic       locked;
        logic       error;
        logic       lost;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [7:0] w;
        logic [7:0] s;
        int         gap;

        rst_ni = 1'b0; in_valid_i = 1'b0; in_data_i = 8'h00; clear_i = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("reset.locked", int'(locked_o), 0);
        check("reset.error", int'(error_o), 0);
        check("reset.lock_lost", int'(lock_lost_o), 0);
        check("reset.err_count", int'(err_count_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Lock acquisition, single error, recovery, loss of lock, clear.
        tbl.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b1, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b1, 8'h13, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
        tbl.push_back('{1'b1, 8'h2C, 1'b0, 1'b1, 1'b1, 1'b0, 4'd1});
        tbl.push_back('{1'b1, 8'h64, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1});
        tbl.push_back('{1'b1, 8'hDA, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3});
        tbl.push_back('{1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4});
        tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0});

        foreach (tbl[i]) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].c);
            check($sformatf("tbl%0d.locked", i), int'(locked_o), int'(tbl[i].locked));
            check($sformatf("tbl%0d.error", i), int'(error_o), int'(tbl[i].error));
            check($sformatf("tbl%0d.lock_lost", i), int'(lock_lost_o), int'(tbl[i].lost));
            check($sformatf("tbl%0d.err_count", i), int'(err_count_o), int'(tbl[i].cnt));
        end

        // Zeros never seed; then 0x55 forces a reseed in VERIFY.
        repeat (5) cyc(1'b1, 8'h00, 1'b0);
        check("zero.locked", int'(locked_o), 0);
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        cyc(1'b1, 8'h55, 1'b0);
        check("reseed.no_error", int'(error_o), 0);
        w = 8'h55;
        for (int k = 1; k <= 4; k++) begin
            w = f(w);
            cyc(1'b1, w, 1'b0);
            check($sformatf("reseed.locked%0d", k), int'(locked_o), (k == 4) ? 1 : 0);
        end

        // Idle gaps between correct words are transparent.
        for (int k = 0; k < 8; k++) begin
            w = f(w);
            cyc(1'b1, w, 1'b0);
            check("gap.error", int'(error_o), 0);
            gap = $urandom_range(1, 5);
            repeat (gap) cyc(1'b0, 8'hA5, 1'b0);
        end
        check("gap.locked", int'(locked_o), 1);

        // Clear on the same edge as a mismatch: pulse still fires, count is 0.
        w = f(w);
        cyc(1'b1, w ^ 8'h01, 1'b0);
        check("clr.pre_count", int'(err_count_o), 1);
        w = f(w);
        cyc(1'b1, w ^ 8'h10, 1'b1);
        check("clr.error", int'(error_o), 1);
        check("clr.err_count", int'(err_count_o), 0);
        check("clr.locked", int'(locked_o), 1);
        w = f(w);
        cyc(1'b1, w, 1'b0);

        // Saturation: 20 isolated errors with ERR_W=4.
        for (int k = 0; k < 20; k++) begin
            w = f(w);
            cyc(1'b1, ~w, 1'b0);
            w = f(w);
            cyc(1'b1, w, 1'b0);
        end
        check("sat.err_count", int'(err_count_o), 15);
        check("sat.locked", int'(locked_o), 1);

        // Asynchronous reset mid-stream, away from any clock edge.
        w = f(w);
        cyc(1'b1, ~w, 1'b0);
        #2;
        rst_ni = 1'b0;
        in_valid_i = 1'b0;
        #1;
        model_reset();
        check("arst.locked", int'(locked_o), 0);
        check("arst.error", int'(error_o), 0);
        check("arst.lock_lost", int'(lock_lost_o), 0);
        check("arst.err_count", int'(err_count_o), 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Randomized stream: a true CA chain with corruptions, zeros, gaps, clears.
        s = 8'($urandom_range(1, 255));
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 99) < 20) begin
                cyc(1'b0, 8'($urandom), ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
            end else begin
                int r;
                r = $urandom_range(0, 99);
                if (r < 6)       w = 8'($urandom);
                else if (r < 8)  w = 8'h00;
                else if (r < 10) w = s ^ 8'h80;
                else             w = s;
                s = f(s);
                if (s == 8'h00) s = 8'($urandom_range(1, 255));
                cyc(1'b1, w, ($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ca_seq_checker_8bit.md
# ca_seq_checker_8bit

Receive-side checker for the 8-bit hybrid rule-90/150 cellular-automaton (CA) pseudo-random sequence used as test pattern traffic. It samples a word stream from a link or loopback path and self-synchronises by seeding an internal CA model from the received data. Once synchronised, it flags every word that deviates from the predicted sequence and keeps a saturating error count, so one bench or BIST wrapper can score link integrity end to end.

## Interface
- LOCK_COUNT, default 4: consecutive correct predictions required to declare lock (range 1..15).
- LOSS_THRESH, default 3: consecutive mismatches while locked that drop lock (range 1..15).
- ERR_W, default 16: width of the error counter.

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  in_data is sampled on this clock edge.
- in_data  in  8  received CA word.
- clear  in  1  synchronous clear of err_count.
- locked  out  1  high while in LOCKED.
- error  out  1  one-cycle pulse per mismatching word while LOCKED.
- lock_lost  out  1  one-cycle pulse on the LOCKED->HUNT transition.
- err_count  out  ERR_W  saturating count of LOCKED mismatches.

## Operation
- CA next-state function f(s) over bits 7..0 (rule pattern R90,R90,R150,R90,R150,R90,R150,R90 from MSB, null boundaries):
  - n7=s6, n6=s7^s5, n5=s6^s5^s4, n4=s5^s3
  - n3=s4^s3^s2, n2=s3^s1, n1=s2^s1^s0, n0=s1
- Internal state: expected[7:0], FSM state, match_run and miss_run counters (4 bits each).
- The FSM acts only on cycles with in_valid=1. Otherwise all state holds.
- HUNT:
  - If in_data != 0: expected <= f(in_data), match_run <= 0, go to VERIFY.
  - If in_data == 0: stay in HUNT. Zero is a fixed point of f and is never used as a seed.
- VERIFY:
  - Match (in_data==expected): expected <= f(in_data), match_run+1. When match_run+1 == LOCK_COUNT, go to LOCKED with miss_run <= 0.
  - Mismatch, in_data != 0: reseed with expected <= f(in_data), match_run <= 0, stay in VERIFY.
  - Mismatch, in_data == 0: go to HUNT.
  - No errors are counted in VERIFY.
- LOCKED:
  - expected <= f(expected) on every valid word (free-running; the model is never reseeded from data).
  - Match: miss_run <= 0.
  - Mismatch: error pulse, err_count+1 (saturating at all-ones), miss_run+1.
  - When miss_run+1 == LOSS_THRESH: go to HUNT and pulse lock_lost. The error pulse and count increment for that word still occur.
- clear:
  - Sets err_count <= 0 on any edge.
  - When clear and a counted mismatch occur on the same edge, clear wins (count = 0). The error pulse is still asserted.
  - clear does not affect the FSM state or locked.

## Timing
- Reset values:
  - FSM = HUNT, expected = 0x00, match_run = 0, miss_run = 0.
  - locked = 0, error = 0, lock_lost = 0, err_count = 0.
- Reset is asynchronous. Asserting it mid-stream returns the block to HUNT immediately, with all outputs at their reset values.
- All outputs are registered.
  - error and lock_lost are high for exactly the cycle after the edge that sampled the offending word.
  - err_count updates on that same cycle.
- locked rises the cycle after the LOCK_COUNT-th consecutive match is sampled. Minimum acquisition is 1+LOCK_COUNT valid words.
- locked falls together with the lock_lost pulse.
- Gaps in in_valid are transparent: prediction advances per valid word, not per clock.
- Throughput: one word per clock, with no back-pressure.

## Test plan
- Lock acquisition (LOCK_COUNT=4): drive 0x01,0x02,0x07,0x0F,0x13 back-to-back -> locked=1 the cycle after 0x13 is sampled; err_count=0; error never pulses.
- Single error while locked: after lock, drive 0x2C in place of the expected 0x2D, then continue from f(0x2D) -> one error pulse, err_count=1, locked stays 1.
- Loss of lock (LOSS_THRESH=3): after lock, drive three consecutive wrong words -> three error pulses, err_count=3. lock_lost pulses with the third. locked=0 and the FSM is in HUNT.
- Zero seed and VERIFY reseed:
  - Drive 0x00 repeatedly -> the block stays in HUNT.
  - Drive 0x01, 0x02, 0x55 -> the block reseeds from 0x55, and lock needs 4 further correct words after 0x55.
- Idle gaps and clear:
  - Locked stream with in_valid low for 1-5 cycles between words -> no errors.
  - Pulse clear on the same edge as a mismatch -> error pulse, err_count=0.
- Saturation and reset: use ERR_W=4 and inject 20 isolated errors while locked -> err_count holds at 0xF. Asserting reset mid-stream -> all outputs 0 immediately.
